// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2
    } kp_state_t;

    localparam int KP_ROWS   = 4;
    localparam int KP_COLS   = 4;
    localparam int KP_CODE_W = 4;

    localparam logic [KP_COLS-1:0] KP_COL_IDLE = 4'b1111;

    // Returns {exactly_one_low, low_column_index}; ghosted or idle columns give 3'b000.
    function automatic logic [2:0] single_low(input logic [KP_COLS-1:0] col);
        logic [2:0] res;
        res = 3'b000;
        case (col)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the raw keypad columns; resets to the idle pattern.
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KP_COLS-1:0] col_n,
    output logic [KP_COLS-1:0] col_s
);

    logic [KP_COLS-1:0] col_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= KP_COL_IDLE;
            col_s    <= KP_COL_IDLE;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce and a one-deep valid/ready code buffer.
// Optional build macro: KEYPAD_AUTOREPEAT_EN re-emits a held key every REPEAT_CNT samples.
//
// state        | meaning
// SCAN         | rotating rows, looking for a single low column
// DEBOUNCE     | row frozen, counting matching samples of the candidate key
// WAIT_RELEASE | key confirmed and held, counting idle samples before rescanning
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 10,
    parameter int REPEAT_CNT   = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KP_COLS-1:0]   col_n,
    output logic [KP_ROWS-1:0]   row_n,
    output logic [KP_CODE_W-1:0] key_code,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic                 key_held,
    output logic                 key_overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CNT < 1) begin : g_bad_params
        $error("keypad_scanner: SCAN_DIV >= 4, DEBOUNCE_CNT >= 2, REPEAT_CNT >= 1 required");
    end

    logic [KP_COLS-1:0] col_s;

    keypad_col_sync u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .col_n (col_n),
        .col_s (col_s)
    );

    // Period timer: the terminal count is the sample point and also the only row-change edge.
    logic [DIV_W-1:0] div_cnt;
    logic             sample;

    assign sample = (div_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= DIV_W'(SCAN_DIV - 1);
        end else if (sample) begin
            div_cnt <= DIV_W'(SCAN_DIV - 1);
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    kp_state_t        state;
    logic [1:0]       row_idx;
    logic [1:0]       next_row;
    logic [1:0]       cand_row;
    logic [1:0]       cand_col;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       hit;
    logic             col_hit;
    logic [1:0]       col_idx;
    logic             fire;

    assign hit      = single_low(col_s);
    assign col_hit  = hit[2];
    assign col_idx  = hit[1:0];
    assign next_row = row_idx + 2'd1;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_CNT + 1);
    logic [HOLD_W-1:0] hold_cnt;
`endif

    // fire = the confirm action this edge (first confirm, or an auto-repeat).
    always_comb begin
        fire = 1'b0;
        if (sample) begin
            if (state == DEBOUNCE && col_hit && col_idx == cand_col &&
                cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                fire = 1'b1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (state == WAIT_RELEASE && col_s != KP_COL_IDLE &&
                hold_cnt == HOLD_W'(REPEAT_CNT - 1)) begin
                fire = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            row_idx     <= 2'd0;
            row_n       <= 4'b1110;
            cand_row    <= 2'd0;
            cand_col    <= 2'd0;
            cnt         <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_overrun <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            if (key_valid && key_ready) begin
                key_valid   <= 1'b0;
                key_overrun <= 1'b0;
            end
            // A load overrides the accept above when both land on the same edge.
            if (fire) begin
                if (!key_valid || key_ready) begin
                    key_code  <= {cand_row, cand_col};
                    key_valid <= 1'b1;
                end else begin
                    key_overrun <= 1'b1;
                end
            end

            if (sample) begin
                case (state)
                    SCAN: begin
                        if (col_hit) begin
                            cand_row <= row_idx;
                            cand_col <= col_idx;
                            cnt      <= CNT_W'(1);
                            state    <= DEBOUNCE;
                        end else begin
                            row_idx <= next_row;
                            row_n   <= ~(4'b0001 << next_row);
                        end
                    end
                    DEBOUNCE: begin
                        if (col_hit && col_idx == cand_col) begin
                            if (fire) begin
                                state    <= WAIT_RELEASE;
                                cnt      <= '0;
                                key_held <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                                hold_cnt <= '0;
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            row_idx <= next_row;
                            row_n   <= ~(4'b0001 << next_row);
                        end
                    end
                    WAIT_RELEASE: begin
                        if (col_s == KP_COL_IDLE) begin
                            if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                                state    <= SCAN;
                                cnt      <= '0;
                                key_held <= 1'b0;
                                row_idx  <= next_row;
                                row_n    <= ~(4'b0001 << next_row);
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            hold_cnt <= fire ? '0 : hold_cnt + 1'b1;
`endif
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule
